// File: rtl/dl_rom_sequencer_if.sv
// Write-port bundle between the ROM download sequencer and the shared ROM/PROM write port.
// master (sequencer): drives wr_req, wr_addr, wr_data, wr_region; receives wr_ack.
// slave (memory arbiter side): mirror image of master.
interface dl_rom_sequencer_if;
  logic        wr_req;
  logic        wr_ack;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  wr_region;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    output wr_region,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    input  wr_region,
    output wr_ack
  );
endinterface

// File: rtl/dl_rom_sequencer.sv
// Purpose: buffers the ioctl ROM download, decodes regions, writes via req/ack, owns core reset.
// Latency: ioctl_wr into an empty FIFO -> wr_req after 2 clk_sys edges; 1 write/cycle with ack held.
// Backpressure: none upstream; FIFO_DEPTH unacked bytes max, extra bytes dropped and flagged.
// Ports: clk_sys/Reset_n; ioctl_download/wr/addr/dout download stream; ext_reset OSD reset request;
//        wr_port (req/ack write port, master side); core_reset_n, dl_busy, overflow status.
module dl_rom_sequencer #(
  parameter logic [16:0] PROG_END    = 17'h01000,
  parameter logic [16:0] CHAR_END    = 17'h01800,
  parameter logic [16:0] MOTN_END    = 17'h02000,
  parameter logic [16:0] PROM_END    = 17'h02200,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 4096
) (
  input  logic                      clk_sys,
  input  logic                      Reset_n,
  input  logic                      ioctl_download,
  input  logic                      ioctl_wr,
  input  logic [16:0]               ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  input  logic                      ext_reset,
  dl_rom_sequencer_if.master        wr_port,
  output logic                      core_reset_n,
  output logic                      dl_busy,
  output logic                      overflow
);

  localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   PTR_WRAP  = {1'b1, {AW{1'b0}}};

  typedef struct packed {
    logic [3:0]  region;
    logic [12:0] offset;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  entry_t        mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_next;
  entry_t        push_ent, out_q;
  logic [16:0]   base;
  logic          in_range, fifo_full, push_req, push_ok, ovf_set, pop, head_avail;
  logic          wr_req_q, dl_q, dl_rise, dl_fall, drain_done;

  // Region decode at push time; offset is relative to the region base.
  always_comb begin
    push_ent = '0;
    base     = '0;
    if (ioctl_addr < PROG_END) begin
      push_ent.region = 4'b0001;
      base            = '0;
    end else if (ioctl_addr < CHAR_END) begin
      push_ent.region = 4'b0010;
      base            = PROG_END;
    end else if (ioctl_addr < MOTN_END) begin
      push_ent.region = 4'b0100;
      base            = CHAR_END;
    end else if (ioctl_addr < PROM_END) begin
      push_ent.region = 4'b1000;
      base            = MOTN_END;
    end
    push_ent.offset = 13'(ioctl_addr - base);
    push_ent.data   = ioctl_dout;
  end

  assign in_range  = |push_ent.region;
  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;

  // The presented write stays in the FIFO until acked, so occupancy counts it.
  assign fifo_full = (wr_ptr ^ rd_ptr) == PTR_WRAP;
  assign pop       = wr_req_q & wr_port.wr_ack;
  assign push_req  = ioctl_download & ioctl_wr & in_range;
  assign push_ok   = push_req & (~fifo_full | pop);
  assign ovf_set   = push_req & fifo_full & ~pop;

  // Head after this cycle's pop; a byte pushed this cycle is not visible until next cycle.
  assign rd_next    = rd_ptr + (AW+1)'(pop);
  assign head_avail = rd_next != wr_ptr;

  // Last write consumed (or nothing pending) and nothing new arriving.
  assign drain_done = ~push_ok & ~head_avail & (~wr_req_q | pop);

  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_ent;
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_req_q <= 1'b0;
      out_q    <= '0;
      overflow <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      dl_q   <= ioctl_download;
      rd_ptr <= rd_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      // Reload the output register only when it is idle or just consumed.
      if (pop || !wr_req_q) begin
        wr_req_q <= head_avail;
        if (head_avail) begin
          out_q <= mem[rd_next[AW-1:0]];
        end
      end
      // A drop on the same cycle as a new download start still sets the flag.
      overflow <= (overflow & ~dl_rise) | ovf_set;
    end
  end

  assign wr_port.wr_req    = wr_req_q;
  assign wr_port.wr_addr   = out_q.offset;
  assign wr_port.wr_data   = out_q.data;
  assign wr_port.wr_region = out_q.region;

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      core_reset_n <= 1'b0;
      dl_busy      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_n <= (state_d == RUN);
      dl_busy      <= (state_d != RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Power-up reset when no download arrives.
        cnt_d = cnt_q + CW'(1);
        if (ioctl_download) begin
          state_d = LOAD;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (dl_fall) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dl_rise) begin
          state_d = LOAD;
        end else if (drain_done) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (dl_rise) begin
          state_d = LOAD;
        end else if (ext_reset) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (dl_rise) begin
          state_d = LOAD;
        end else if (ext_reset) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
